// File: rtl/wave_controller.sv
// Game-level sequencer around alien_group: score, lives, wave number and alien speed.
// Optional HISCORE_EN adds a high-score register updated on entry to GAME_OVER.
module wave_controller #(
  parameter int unsigned TOTAL_ALIENS   = 32,
  parameter int unsigned BASE_SPEED     = 1,
  parameter int unsigned MAX_SPEED      = 8,
  parameter int unsigned POINTS_PER_HIT = 10,
  parameter int unsigned START_LIVES    = 3,
  parameter int unsigned CLEAR_FRAMES   = 120,
  parameter int unsigned RESPAWN_FRAMES = 60,
  parameter int unsigned SCORE_W        = 16
) (
  input  logic                                 pixel_clk,
  input  logic                                 rst_n,
  input  logic                                 fsync,
  input  logic                                 start_btn,
  input  logic                                 alien_hit,
  input  logic [$clog2(TOTAL_ALIENS+1)-1:0]    aliens_remaining,
  input  logic                                 player_hit,
  input  logic                                 aliens_landed,
  output logic [7:0]                           speed,
  output logic                                 group_rst,
  output logic                                 play_active,
  output logic [7:0]                           wave_num,
  output logic [SCORE_W-1:0]                   score,
  output logic [3:0]                           lives,
  output logic                                 game_over,
  output logic [2:0]                           state
`ifdef HISCORE_EN
  ,
  output logic [SCORE_W-1:0]                   hiscore
`endif
);

  localparam int unsigned REM_W   = $clog2(TOTAL_ALIENS + 1);
  localparam int unsigned MAX_FR  = (CLEAR_FRAMES > RESPAWN_FRAMES) ? CLEAR_FRAMES : RESPAWN_FRAMES;
  localparam int unsigned CNT_W   = $clog2(MAX_FR + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAVE_START = 3'd1,
    S_PLAY       = 3'd2,
    S_RESPAWN    = 3'd3,
    S_WAVE_CLEAR = 3'd4,
    S_GAME_OVER  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           speed_q, speed_d;
  logic [7:0]           wave_num_q, wave_num_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [3:0]           lives_q, lives_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 group_rst_q, play_active_q, game_over_q;
  logic                 start_q, hit_q, phit_q;

  logic                 start_rise, hit_rise, phit_rise;
  logic [SCORE_W:0]     score_sum;
  logic [1:0]           boost;
  logic [8:0]           raw_speed;
  logic [7:0]           speed_calc;

  assign start_rise = start_btn  & ~start_q;
  assign hit_rise   = alien_hit  & ~hit_q;
  assign phit_rise  = player_hit & ~phit_q;

  // Speed candidate for the current wave and alien count; 9 bits so the sum cannot wrap.
  always_comb begin
    boost = 2'd0;
    if (32'(aliens_remaining) <= TOTAL_ALIENS / 4)      boost = 2'd2;
    else if (32'(aliens_remaining) <= TOTAL_ALIENS / 2) boost = 2'd1;
    raw_speed = 9'(BASE_SPEED) + 9'(wave_num_q) - 9'd1 + 9'(boost);
    if (aliens_remaining == REM_W'(1)) raw_speed = 9'(MAX_SPEED);
    speed_calc = (raw_speed > 9'(MAX_SPEED)) ? 8'(MAX_SPEED) : raw_speed[7:0];
  end

  assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(POINTS_PER_HIT);

  always_comb begin
    state_d    = state_q;
    wave_num_d = wave_num_q;
    score_d    = score_q;
    lives_d    = lives_q;
    cnt_d      = cnt_q;
    speed_d    = speed_q;

    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_rise) begin
          state_d    = S_WAVE_START;
          wave_num_d = 8'd1;
          score_d    = '0;
          lives_d    = 4'(START_LIVES);
        end
      end
      S_WAVE_START: begin
        if (fsync) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (aliens_landed) begin
          lives_d = 4'd0;
          state_d = S_GAME_OVER;
        end else if (phit_rise) begin
          lives_d = lives_q - 4'd1;
          state_d = (lives_q == 4'd1) ? S_GAME_OVER : S_RESPAWN;
        end else if (fsync && aliens_remaining == REM_W'(0)) begin
          state_d = S_WAVE_CLEAR;
        end
      end
      S_RESPAWN: begin
        if (fsync && cnt_q == CNT_W'(RESPAWN_FRAMES - 1)) state_d = S_PLAY;
      end
      S_WAVE_CLEAR: begin
        if (fsync && cnt_q == CNT_W'(CLEAR_FRAMES - 1)) begin
          state_d    = S_WAVE_START;
          wave_num_d = (wave_num_q == 8'hFF) ? 8'hFF : wave_num_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Hits landing on a PLAY exit cycle still score.
    if (hit_rise && (state_q inside {S_PLAY, S_RESPAWN, S_WAVE_CLEAR}))
      score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    if (state_d != state_q) cnt_d = '0;
    else if (fsync)         cnt_d = cnt_q + CNT_W'(1);

    if (state_d != S_PLAY)                 speed_d = 8'd0;
    else if (state_q == S_PLAY && fsync)   speed_d = speed_calc;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      speed_q       <= 8'd0;
      wave_num_q    <= 8'd0;
      score_q       <= '0;
      lives_q       <= 4'd0;
      cnt_q         <= '0;
      group_rst_q   <= 1'b1;
      play_active_q <= 1'b0;
      game_over_q   <= 1'b0;
      start_q       <= 1'b0;
      hit_q         <= 1'b0;
      phit_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      speed_q       <= speed_d;
      wave_num_q    <= wave_num_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      cnt_q         <= cnt_d;
      group_rst_q   <= (state_d == S_IDLE) || (state_d == S_WAVE_START);
      play_active_q <= (state_d == S_PLAY);
      game_over_q   <= (state_d == S_GAME_OVER);
      start_q       <= start_btn;
      hit_q         <= alien_hit;
      phit_q        <= player_hit;
    end
  end

`ifdef HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hiscore_q <= '0;
    end else if (state_d == S_GAME_OVER && state_q != S_GAME_OVER && score_d > hiscore_q) begin
      hiscore_q <= score_d;
    end
  end

  assign hiscore = hiscore_q;
`endif

  assign speed       = speed_q;
  assign group_rst   = group_rst_q;
  assign play_active = play_active_q;
  assign wave_num    = wave_num_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign game_over   = game_over_q;
  assign state       = state_q;

endmodule

// File: tb/tb_wave_controller.sv
// Bench for wave_controller: directed game flow, randomized play against a frame-level model,
// and score saturation.
module tb_wave_controller;

  localparam int TOTAL   = 32;
  localparam int MAXSPD  = 8;
  localparam int PTS     = 10;
  localparam int LIVES0  = 3;
  localparam int CLEARN  = 120;
  localparam int RESPN   = 60;
  localparam int SMAX    = 65535;
  localparam int FRAME   = 8;

  logic        pixel_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fsync = 1'b0;
  logic        start_btn = 1'b0;
  logic        alien_hit = 1'b0;
  logic [5:0]  aliens_remaining = 6'd32;
  logic        player_hit = 1'b0;
  logic        aliens_landed = 1'b0;
  logic [7:0]  speed;
  logic        group_rst;
  logic        play_active;
  logic [7:0]  wave_num;
  logic [15:0] score;
  logic [3:0]  lives;
  logic        game_over;
  logic [2:0]  state;
`ifdef HISCORE_EN
  logic [15:0] hiscore;
`endif

  wave_controller dut (
    .pixel_clk        (pixel_clk),
    .rst_n            (rst_n),
    .fsync            (fsync),
    .start_btn        (start_btn),
    .alien_hit        (alien_hit),
    .aliens_remaining (aliens_remaining),
    .player_hit       (player_hit),
    .aliens_landed    (aliens_landed),
    .speed            (speed),
    .group_rst        (group_rst),
    .play_active      (play_active),
    .wave_num         (wave_num),
    .score            (score),
    .lives            (lives),
    .game_over        (game_over),
    .state            (state)
`ifdef HISCORE_EN
    ,
    .hiscore          (hiscore)
`endif
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: game state held as plain integers, advanced once per clock.
  int m_state, m_speed, m_wave, m_score, m_lives, m_frames, m_hi;
  bit p_start, p_hit, p_phit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int speed_rule(input int wave, input int rem);
    int boost, raw;
    boost = (rem <= TOTAL / 4) ? 2 : (rem <= TOTAL / 2) ? 1 : 0;
    raw = 1 + (wave - 1) + boost;
    if (rem == 1) raw = MAXSPD;
    return (raw > MAXSPD) ? MAXSPD : raw;
  endfunction

  task automatic model_reset();
    m_state = 0; m_speed = 0; m_wave = 0; m_score = 0; m_lives = 0; m_frames = 0; m_hi = 0;
    p_start = 0; p_hit = 0; p_phit = 0;
  endtask

  task automatic new_game();
    m_wave = 1; m_score = 0; m_lives = LIVES0;
  endtask

  task automatic model_step();
    int old_s, nxt;
    bit sr, hr, pr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    old_s = m_state;
    nxt   = m_state;
    sr = start_btn && !p_start;
    hr = alien_hit && !p_hit;
    pr = player_hit && !p_phit;
    case (old_s)
      0, 5: if (sr) begin nxt = 1; new_game(); end
      1: if (fsync) nxt = 2;
      2: begin
        if (aliens_landed) begin m_lives = 0; nxt = 5; end
        else if (pr) begin m_lives = m_lives - 1; nxt = (m_lives == 0) ? 5 : 3; end
        else if (fsync && aliens_remaining == 0) nxt = 4;
      end
      3: if (fsync) begin m_frames++; if (m_frames == RESPN) nxt = 2; end
      4: if (fsync) begin
           m_frames++;
           if (m_frames == CLEARN) begin nxt = 1; m_wave = (m_wave >= 255) ? 255 : m_wave + 1; end
         end
      default: nxt = 0;
    endcase
    if (hr && (old_s == 2 || old_s == 3 || old_s == 4))
      m_score = (m_score + PTS > SMAX) ? SMAX : m_score + PTS;
    if (nxt != old_s) m_frames = 0;
    if (nxt == 5 && old_s != 5 && m_score > m_hi) m_hi = m_score;
    if (nxt != 2) m_speed = 0;
    else if (old_s == 2 && fsync) m_speed = speed_rule(m_wave, int'(aliens_remaining));
    p_start = start_btn; p_hit = alien_hit; p_phit = player_hit;
    m_state = nxt;
  endtask

  task automatic compare_all();
    check("state",       32'(state),       32'(m_state));
    check("speed",       32'(speed),       32'(m_speed));
    check("wave_num",    32'(wave_num),    32'(m_wave));
    check("score",       32'(score),       32'(m_score));
    check("lives",       32'(lives),       32'(m_lives));
    check("group_rst",   32'(group_rst),   32'(m_state == 0 || m_state == 1));
    check("play_active", 32'(play_active), 32'(m_state == 2));
    check("game_over",   32'(game_over),   32'(m_state == 5));
`ifdef HISCORE_EN
    check("hiscore",     32'(hiscore),     32'(m_hi));
`endif
  endtask

  // One clock: model consumes the inputs presented now, DUT clocks them, outputs compared after the edge.
  task automatic tick();
    model_step();
    @(posedge pixel_clk);
    #1;
    compare_all();
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      fsync = 1'b1;
      tick();
      fsync = 1'b0;
      repeat (FRAME - 1) tick();
    end
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    tick();
  endtask

  task automatic hit_pulse(input int width);
    alien_hit = 1'b1;
    repeat (width) tick();
    alien_hit = 1'b0;
    repeat (2) tick();
  endtask

  task automatic player_pulse();
    player_hit = 1'b1;
    repeat (2) tick();
    player_hit = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_group_rst", 32'(group_rst), 32'd1);

    // Game start and first wave speed
    press_start();
    check("start_wave", 32'(wave_num), 32'd1);
    check("start_lives", 32'(lives), 32'd3);
    check("start_grst", 32'(group_rst), 32'd1);
    frames(1);
    check("play_entry_speed", 32'(speed), 32'd0);
    frames(1);
    check("wave1_speed", 32'(speed), 32'd1);

    // Stretched hit pulses count once each
    for (int i = 0; i < 4; i++) hit_pulse(3);
    check("score40", 32'(score), 32'd40);
    aliens_remaining = 6'd16; frames(1); check("speed_half", 32'(speed), 32'd2);
    aliens_remaining = 6'd8;  frames(1); check("speed_quarter", 32'(speed), 32'd3);
    aliens_remaining = 6'd1;  frames(1); check("speed_last", 32'(speed), 32'd8);
    hit_pulse(1);
    aliens_remaining = 6'd8;  frames(1);
    check("pre_rst_score", 32'(score), 32'd50);
    check("pre_rst_speed", 32'(speed), 32'd3);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_state", 32'(state), 32'd0);
    check("async_speed", 32'(speed), 32'd0);
    check("async_grst", 32'(group_rst), 32'd1);
    check("async_score", 32'(score), 32'd0);
    tick();
    rst_n = 1'b1;
    aliens_remaining = 6'd32;
    tick();

    // Wave clear and second wave
    press_start();
    frames(1);
    hit_pulse(1);
    hit_pulse(2);
    aliens_remaining = 6'd0;
    frames(1);
    check("clear_state", 32'(state), 32'd4);
    check("clear_speed", 32'(speed), 32'd0);
    frames(CLEARN - 1);
    check("clear_hold", 32'(state), 32'd4);
    frames(1);
    check("clear_exit", 32'(state), 32'd1);
    check("wave2", 32'(wave_num), 32'd2);
    aliens_remaining = 6'd32;
    frames(2);
    check("wave2_speed", 32'(speed), 32'd2);

    // Lives run out
    player_pulse();
    check("lives2", 32'(lives), 32'd2);
    check("respawn", 32'(state), 32'd3);
    frames(RESPN);
    check("respawn_exit", 32'(state), 32'd2);
    player_pulse();
    check("lives1", 32'(lives), 32'd1);
    frames(RESPN);
    player_pulse();
    check("lives0", 32'(lives), 32'd0);
    check("gameover_flag", 32'(game_over), 32'd1);
    check("gameover_score", 32'(score), 32'd20);
    press_start();
    check("restart_score", 32'(score), 32'd0);
    check("restart_lives", 32'(lives), 32'd3);

    // Player hit on the same fsync as the wave clear
    frames(1);
    aliens_remaining = 6'd0;
    player_hit = 1'b1;
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    player_hit = 1'b0;
    repeat (FRAME - 1) tick();
    check("simul_state", 32'(state), 32'd3);
    check("simul_lives", 32'(lives), 32'd2);
    frames(RESPN);
    check("simul_play", 32'(state), 32'd2);
    frames(1);
    check("simul_clear", 32'(state), 32'd4);

    // Randomized play
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int f = 0; f < 600; f++) begin
      aliens_remaining = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, TOTAL));
      for (int c = 0; c < FRAME; c++) begin
        fsync = (c == 0);
        if ($urandom_range(0, 63) == 0) start_btn = ~start_btn;
        if (m_state == 5) alien_hit = 1'b0;
        else if ($urandom_range(0, 2) == 0) alien_hit = ~alien_hit;
        if (player_hit) player_hit = ($urandom_range(0, 1) == 0);
        else player_hit = ($urandom_range(0, 59) == 0);
        aliens_landed = ($urandom_range(0, 1499) == 0);
        rst_n = ($urandom_range(0, 2999) != 0);
        tick();
      end
    end
    fsync = 1'b0; start_btn = 1'b0; alien_hit = 1'b0; player_hit = 1'b0; aliens_landed = 1'b0;
    rst_n = 1'b1;

    // Score saturation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    aliens_remaining = 6'd32;
    tick();
    press_start();
    frames(1);
    for (int f = 0; f < 1700; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        fsync = (c == 0);
        alien_hit = (c % 2 == 0);
        tick();
      end
    end
    fsync = 1'b0;
    alien_hit = 1'b0;
    tick();
    check("score_sat", 32'(score), 32'd65535);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
